// File: rtl/mbus_arb.sv
// mbus_arb: round-robin arbiter sharing one single-beat memory bus among NREQ masters.
// Each request is granted once and driven onto the mbus_* strobes. The arbiter then waits
// for mbus_ack and returns a one-cycle done pulse with read data to the winner.
// Optional feature macro: MBUS_ARB_TIMEOUT_EN. When it is defined, a transfer that sees no
// ack within TIMEOUT bus cycles is aborted and reported through req_err.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/we         per-requester request level and direction (1 = write)
//   req_addr/wdata       packed payloads, 48/64 bits per requester
//   req_gnt/done/err     one-hot accept pulse, completion pulse, timeout flag
//   req_rdata            read data, valid with req_done
//   mbus_re/we/addr/wdata bus strobes and payload, held stable for the whole transfer
//   mbus_rdata/ack       bus read data and slave completion
module mbus_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*48-1:0] req_addr,
  input  logic [NREQ*64-1:0] req_wdata,
  output logic [NREQ-1:0]    req_gnt,
  output logic [NREQ-1:0]    req_done,
  output logic [NREQ-1:0]    req_err,
  output logic [63:0]        req_rdata,
  output logic               mbus_re,
  output logic               mbus_we,
  output logic [47:0]        mbus_addr,
  output logic [63:0]        mbus_wdata,
  input  logic [63:0]        mbus_rdata,
  input  logic               mbus_ack
);

  localparam int unsigned IdW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("mbus_arb: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [0:0] {StIdle, StBus} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [NREQ-1:0]  req_gnt_q, req_gnt_d;
  logic [NREQ-1:0]  req_done_q, req_done_d;
  logic [63:0]      req_rdata_q, req_rdata_d;
  logic             mbus_re_q, mbus_re_d;
  logic             mbus_we_q, mbus_we_d;
  logic [47:0]      mbus_addr_q, mbus_addr_d;
  logic [63:0]      mbus_wdata_q, mbus_wdata_d;

  logic             found;
  logic [IdW-1:0]   win;
  logic             ack_fire;
  logic             expire;
  logic             finish;

  // ack only counts while a strobe is up, which is exactly the BUS state
  assign ack_fire = (state_q == StBus) && mbus_ack;

`ifdef MBUS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] req_err_q, req_err_d;
  // Expiry is the edge on which the counter would reach TIMEOUT; an ack on that edge wins.
  assign expire  = (state_q == StBus) && !mbus_ack && (cnt_q == CntW'(TIMEOUT - 1));
  assign req_err = req_err_q;
`else
  assign expire  = 1'b0;
  assign req_err = '0;
`endif

  assign finish = ack_fire || expire;

  // Round-robin pick: first set request scanning upward from rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IdW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (found) state_d = StBus;
      StBus:  if (finish) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    req_gnt_d    = '0;
    req_done_d   = '0;
    req_rdata_d  = '0;
    mbus_re_d    = mbus_re_q;
    mbus_we_d    = mbus_we_q;
    mbus_addr_d  = mbus_addr_q;
    mbus_wdata_d = mbus_wdata_q;
    id_d         = id_q;
    rr_ptr_d     = rr_ptr_q;
`ifdef MBUS_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    req_err_d    = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          id_d           = win;
          req_gnt_d[win] = 1'b1;
          mbus_we_d      = req_we[win];
          mbus_re_d      = !req_we[win];
          mbus_addr_d    = req_addr[win*48 +: 48];
          mbus_wdata_d   = req_wdata[win*64 +: 64];
`ifdef MBUS_ARB_TIMEOUT_EN
          cnt_d          = '0;
`endif
        end
      end
      StBus: begin
        if (finish) begin
          mbus_re_d        = 1'b0;
          mbus_we_d        = 1'b0;
          req_done_d[id_q] = 1'b1;
          // Writes and aborted transfers return zero data
          req_rdata_d      = (ack_fire && mbus_re_q) ? mbus_rdata : 64'h0;
          rr_ptr_d         = (id_q == IdW'(NREQ - 1)) ? '0 : id_q + 1'b1;
`ifdef MBUS_ARB_TIMEOUT_EN
          req_err_d[id_q]  = expire;
`endif
        end else begin
`ifdef MBUS_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      id_q         <= '0;
      req_gnt_q    <= '0;
      req_done_q   <= '0;
      req_rdata_q  <= '0;
      mbus_re_q    <= 1'b0;
      mbus_we_q    <= 1'b0;
      mbus_addr_q  <= '0;
      mbus_wdata_q <= '0;
`ifdef MBUS_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      req_err_q    <= '0;
`endif
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      req_gnt_q    <= req_gnt_d;
      req_done_q   <= req_done_d;
      req_rdata_q  <= req_rdata_d;
      mbus_re_q    <= mbus_re_d;
      mbus_we_q    <= mbus_we_d;
      mbus_addr_q  <= mbus_addr_d;
      mbus_wdata_q <= mbus_wdata_d;
`ifdef MBUS_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      req_err_q    <= req_err_d;
`endif
    end
  end

  assign req_gnt    = req_gnt_q;
  assign req_done   = req_done_q;
  assign req_rdata  = req_rdata_q;
  assign mbus_re    = mbus_re_q;
  assign mbus_we    = mbus_we_q;
  assign mbus_addr  = mbus_addr_q;
  assign mbus_wdata = mbus_wdata_q;

endmodule
